// File: rtl/rr_priority_arbiter_pkg.sv
// rr_priority_arbiter_pkg: shared state encoding, default parameters and index-width helper
package rr_priority_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_HOLD_MAX = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mask_prio_enc.sv
// rr_mask_prio_enc: combinational rotating-priority encoder (search starts at last+1, excluded bits ignored)
module rr_mask_prio_enc
    import rr_priority_arbiter_pkg::*;
#(
    parameter  int N    = DEF_N,
    localparam int IDXW = idx_w(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_last,
    input  logic [N-1:0]    i_excl,
    output logic            o_hit,
    output logic [IDXW-1:0] o_win
);

    logic [N-1:0]    w_cand;
    logic [N-1:0]    w_rot;
    logic [IDXW-1:0] w_off;

    assign w_cand = i_req & ~i_excl;

    // Rotate candidates so that bit 0 of w_rot is requester last+1.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_cand[(i + int'(i_last) + 1) % N];
        end
    end

    // Fixed lowest-index-first encoder on the rotated vector.
    always_comb begin
        o_hit = 1'b0;
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_hit = 1'b1;
                w_off = IDXW'(i);
            end
        end
    end

    // Un-rotate the offset back to a requester index; winner defaults to 0 when nothing is pending.
    assign o_win = o_hit ? IDXW'((int'(w_off) + int'(i_last) + 1) % N) : '0;

endmodule

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: round-robin arbiter with held grants; RR_ARB_TIMEOUT_EN adds a tenure limit with forced revoke
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter  int N        = DEF_N,
    parameter  int HOLD_MAX = DEF_HOLD_MAX,
    localparam int IDXW     = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic            any_req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    if (N < 2 || HOLD_MAX < 2) begin : g_bad_param
        $error("rr_priority_arbiter: N and HOLD_MAX must both be >= 2");
    end

    state_t          r_state, w_nxt_state;
    logic [N-1:0]    r_gnt, w_nxt_gnt;
    logic [IDXW-1:0] r_idx, w_nxt_idx;
    logic [IDXW-1:0] r_last, w_nxt_last;
    logic            r_to, w_nxt_to;
    logic            w_hit, w_expire, w_arb;
    logic [IDXW-1:0] w_win;
    logic [N-1:0]    w_excl;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX);
    logic [CW-1:0] r_cnt, w_nxt_cnt;

    assign w_expire  = (r_state == BUSY) && req[r_idx] && (r_cnt == CW'(HOLD_MAX - 1));
    assign w_nxt_cnt = w_arb ? '0 : r_cnt + 1'b1;

    // Tenure counter: restarts on every (re)arbitration, counts cycles of an unbroken hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_nxt_cnt;
    end
`else
    assign w_expire = 1'b0;
`endif

    // A forced revoke hides the current grantee from the search.
    assign w_excl = w_expire ? r_gnt : '0;
    assign w_arb  = (r_state == IDLE) || !req[r_idx] || w_expire;

    rr_mask_prio_enc #(.N(N)) u_enc (
        .i_req  (req),
        .i_last (r_last),
        .i_excl (w_excl),
        .o_hit  (w_hit),
        .o_win  (w_win)
    );

    // Next-state: grant the winner on any arbitration point, drop to IDLE when nobody is left,
    // and re-grant the same requester when a forced revoke finds no one else.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_idx   = r_idx;
        w_nxt_last  = r_last;
        w_nxt_to    = w_expire;
        if (w_arb && w_hit) begin
            w_nxt_state = BUSY;
            w_nxt_gnt   = N'(1) << w_win;
            w_nxt_idx   = w_win;
            w_nxt_last  = w_win;
        end else if (w_arb && !w_expire) begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
            w_nxt_idx   = '0;
        end
    end

    // State and grant registers; last starts at N-1 so the first search begins at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_last  <= IDXW'(N - 1);
            r_to    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_gnt   <= w_nxt_gnt;
            r_idx   <= w_nxt_idx;
            r_last  <= w_nxt_last;
            r_to    <= w_nxt_to;
        end
    end

    assign any_req   = |req;
    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = (r_state == BUSY);
    assign timeout   = r_to;

endmodule
